mpmc10_read_cache: RTL and testbench
====================================

# mpmc10_read_cache

Parametrised multi-channel direct-mapped read cache for the mpmc10 memory controller's streaming read ports (sprite, audio, DMA). Each channel owns a private slice of lines; a request either hits and returns a line in two cycles or misses, fetches the line from the controller over a req/ack handshake, fills, and returns it. Adds miss handling, single-line invalidate, whole-cache flush sweep and hit/miss counters over the previous fixed-size sprite cache.

## Interface
Parameters:
- NCH, 32, number of channels (power of 2)
- LPC, 16, lines per channel (power of 2)
- LW, 128, line width in bits (power of 2, ≥ 32)
- AW, 32, byte address width
- Derived: CB=$clog2(NCH), LB=$clog2(LPC), OB=$clog2(LW/8), IW=CB+LB, TW=AW-OB

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req  in  1  lookup request, accepted when req && req_rdy
- req_rdy  out  1  block idle and able to accept
- req_ch  in  CB  requesting channel
- req_adr  in  AW  byte address; low OB bits ignored
- rsp_vld  out  1  one-cycle response strobe
- rsp_dat  out  LW  line data, held until next rsp_vld
- rsp_hit  out  1  response was a hit, held with rsp_dat
- mem_req  out  1  line fetch request, held until mem_ack
- mem_adr  out  AW  line-aligned fetch address
- mem_ack  in  1  fetch complete; mem_dat valid this cycle
- mem_dat  in  LW  fetched line
- inv  in  1  invalidate one line
- inv_ch  in  CB  channel of line to invalidate
- inv_adr  in  AW  address of line to invalidate
- flush  in  1  invalidate whole cache (pulse)
- flush_busy  out  1  flush sweep in progress
- hit_cnt  out  32  saturating hit count
- miss_cnt  out  32  saturating miss count

## Operation
- Index = {ch, adr[OB+LB-1:OB]}; tag = adr[AW-1:OB]. Line, tag and valid bit stored per index in block RAM (single write port, registered read); valid is not reset by rst, hence the sweep.
- States: FLUSH, IDLE, RD, CMP, MWAIT.
- FLUSH: counter 0..NCH*LPC-1 writes valid=0 at one index per cycle; flush_busy=1, req_rdy=0; after last index -> IDLE.
- IDLE: req_rdy=1. flush has priority over simultaneous req -> FLUSH; else req accepted -> RD, request registered.
- RD: RAM read at registered index -> CMP.
- CMP: hit = valid && stored tag == request tag && no inv to this index in RD or CMP. Hit: rsp_vld, rsp_hit=1, rsp_dat=line, hit_cnt+1 -> IDLE. Miss: mem_req=1, mem_adr={tag,OB'b0}, miss_cnt+1 -> MWAIT.
- MWAIT: on mem_ack: mem_req=0, write mem_dat/tag/valid=1, rsp_vld, rsp_hit=0, rsp_dat=mem_dat -> IDLE.
- inv: accepted any state; clears valid at its index that cycle. Same cycle and index as a fill: valid written 0 (inv wins); response still returned with fetched data. During FLUSH: ignored (sweep clears it).
- flush asserted outside IDLE: latched pending, taken on next IDLE entry ahead of any req.
- Counters saturate at 32'hFFFFFFFF; cleared only by rst.

## Timing
- Reset (async): state=FLUSH, sweep counter=0, rsp_vld=0, rsp_dat=0, rsp_hit=0, mem_req=0, mem_adr=0, hit_cnt=0, miss_cnt=0, flush pending=0; flush_busy=1, req_rdy=0. First req_rdy after NCH*LPC cycles from rst release.
- Hit latency: accept edge E0, rsp_vld high for the cycle after E2 (2 clocks).
- Miss: mem_req high from E2; rsp_vld the cycle after the edge sampling mem_ack; req_rdy returns that same cycle. Zero-wait ack (mem_ack at first MWAIT edge) legal.
- mem_adr stable while mem_req=1. mem_ack outside MWAIT ignored.
- Back-to-back hits: one every 3 cycles (IDLE/RD/CMP).
- rst mid-miss: mem_req drops immediately; controller must discard the outstanding fetch.

## Test plan
- Reset release: flush_busy=1 and req_rdy=0 for exactly 512 cycles (defaults), then req_rdy=1, counters 0.
- Cold miss ch 3, adr 32'h0000_1230: mem_adr=32'h0000_1230; ack with mem_dat=128'hA5.. -> rsp_vld, rsp_hit=0, rsp_dat=A5..; repeat -> hit in 2 cycles, same data, hit_cnt=1, miss_cnt=1.
- Aliasing: ch 3 adr 32'h0001_1230 after above -> miss, fill; ch 4 same adr -> independent miss (channel isolation).
- inv to ch 3 adr 32'h1230 during that index's CMP -> forced miss; inv coincident with fill -> next lookup misses.
- flush during MWAIT -> latched; after response, 512-cycle sweep, req held off, all previous lines miss.
- Simultaneous flush and req in IDLE -> flush taken, req accepted after sweep; mem_ack delayed 50 cycles -> mem_req/mem_adr stable throughout.

Source files
------------

// File: rtl/mpmc10_read_cache.sv
`default_nettype none
// ============================================================================
// Module   : mpmc10_read_cache
// Purpose  : Multi-channel direct-mapped line cache for mpmc10 streaming reads
//            with miss fetch, line invalidate, flush sweep and hit/miss counts.
// Revision : 1.0 - initial release
// ============================================================================
module mpmc10_read_cache #(
  parameter int NCH = 32,
  parameter int LPC = 16,
  parameter int LW  = 128,
  parameter int AW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  output logic          req_rdy,
  input  logic [$clog2(NCH)-1:0] req_ch,
  input  logic [AW-1:0] req_adr,
  output logic          rsp_vld,
  output logic [LW-1:0] rsp_dat,
  output logic          rsp_hit,
  output logic          mem_req,
  output logic [AW-1:0] mem_adr,
  input  logic          mem_ack,
  input  logic [LW-1:0] mem_dat,
  input  logic          inv,
  input  logic [$clog2(NCH)-1:0] inv_ch,
  input  logic [AW-1:0] inv_adr,
  input  logic          flush,
  output logic          flush_busy,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
);
  localparam int CB = $clog2(NCH);
  localparam int LB = $clog2(LPC);
  localparam int OB = $clog2(LW / 8);
  localparam int IW = CB + LB;
  localparam int TW = AW - OB;
  localparam int NL = NCH * LPC;

  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_RD    = 3'd2,
    S_CMP   = 3'd3,
    S_MWAIT = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_sweep, r_idx, w_req_idx, w_inv_idx;
  logic [TW-1:0]   r_tag;
  logic            r_flush_pend, r_inv_seen;
  logic [LW-1:0]   r_line_ram [NL];
  logic [TW-1:0]   r_tag_ram  [NL];
  logic [NL-1:0]   r_valid;
  logic [LW-1:0]   r_rd_line;
  logic [TW-1:0]   r_rd_tag;
  logic            r_rd_valid;
  logic            w_inv_here, w_hit, w_ack, w_flush_go, w_accept;
  logic            w_unused_ok;

  assign w_req_idx  = {req_ch, req_adr[OB+LB-1:OB]};
  assign w_inv_idx  = {inv_ch, inv_adr[OB+LB-1:OB]};
  assign w_inv_here = inv && (w_inv_idx == r_idx);
  // An inv seen while the line is in flight must force a miss even though
  // the registered read may still show the old valid bit.
  assign w_hit      = r_rd_valid && (r_rd_tag == r_tag) && !r_inv_seen && !w_inv_here;
  assign w_ack      = (r_state == S_MWAIT) && mem_ack;
  assign w_flush_go = flush || r_flush_pend;
  assign w_accept   = (r_state == S_IDLE) && req && !w_flush_go;
  assign req_rdy    = (r_state == S_IDLE);
  assign flush_busy = (r_state == S_FLUSH);
  assign w_unused_ok = ^{req_adr[OB-1:0], inv_adr[OB-1:0], inv_adr[AW-1:OB+LB]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FLUSH: if (r_sweep == IW'(NL - 1)) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_flush_go)  w_state_nxt = S_FLUSH;
        else if (req)    w_state_nxt = S_RD;
      end
      S_RD:    w_state_nxt = S_CMP;
      S_CMP:   w_state_nxt = w_hit ? S_IDLE : S_MWAIT;
      S_MWAIT: if (mem_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FLUSH;
      r_sweep      <= '0;
      r_flush_pend <= 1'b0;
      r_idx        <= '0;
      r_tag        <= '0;
      r_inv_seen   <= 1'b0;
      rsp_vld      <= 1'b0;
      rsp_dat      <= '0;
      rsp_hit      <= 1'b0;
      mem_req      <= 1'b0;
      mem_adr      <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      rsp_vld <= 1'b0;
      r_sweep <= (r_state == S_FLUSH) ? r_sweep + IW'(1) : '0;
      if (r_state == S_IDLE)
        r_flush_pend <= 1'b0;
      else if (flush && r_state != S_FLUSH)
        r_flush_pend <= 1'b1;
      if (w_accept) begin
        r_idx <= w_req_idx;
        r_tag <= req_adr[AW-1:OB];
      end
      if (r_state == S_RD)
        r_inv_seen <= w_inv_here;
      if (r_state == S_CMP) begin
        if (w_hit) begin
          rsp_vld <= 1'b1;
          rsp_hit <= 1'b1;
          rsp_dat <= r_rd_line;
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          mem_req <= 1'b1;
          mem_adr <= {r_tag, {OB{1'b0}}};
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
      end
      if (w_ack) begin
        mem_req <= 1'b0;
        rsp_vld <= 1'b1;
        rsp_hit <= 1'b0;
        rsp_dat <= mem_dat;
      end
    end
  end

  // Valid bits carry no reset; the power-up sweep clears them. A coincident
  // inv is applied after the fill so it wins at the same index.
  always_ff @(posedge clk) begin
    r_rd_line  <= r_line_ram[r_idx];
    r_rd_tag   <= r_tag_ram[r_idx];
    r_rd_valid <= r_valid[r_idx];
    if (w_ack) begin
      r_line_ram[r_idx] <= mem_dat;
      r_tag_ram[r_idx]  <= r_tag;
    end
    if (r_state == S_FLUSH) begin
      r_valid[r_sweep] <= 1'b0;
    end else begin
      if (w_ack) r_valid[r_idx] <= 1'b1;
      if (inv)   r_valid[w_inv_idx] <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mpmc10_read_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpmc10_read_cache
// Purpose  : Directed self-checking bench for mpmc10_read_cache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpmc10_read_cache;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic         req_rdy;
  logic [4:0]   req_ch = '0;
  logic [31:0]  req_adr = '0;
  logic         rsp_vld;
  logic [127:0] rsp_dat;
  logic         rsp_hit;
  logic         mem_req;
  logic [31:0]  mem_adr;
  logic         mem_ack = 1'b0;
  logic [127:0] mem_dat = '0;
  logic         inv = 1'b0;
  logic [4:0]   inv_ch = '0;
  logic [31:0]  inv_adr = '0;
  logic         flush = 1'b0;
  logic         flush_busy;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int n_chk = 0;
  int n_err = 0;

  mpmc10_read_cache dut (
    .clk(clk), .rst(rst),
    .req(req), .req_rdy(req_rdy), .req_ch(req_ch), .req_adr(req_adr),
    .rsp_vld(rsp_vld), .rsp_dat(rsp_dat), .rsp_hit(rsp_hit),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack), .mem_dat(mem_dat),
    .inv(inv), .inv_ch(inv_ch), .inv_adr(inv_adr),
    .flush(flush), .flush_busy(flush_busy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_sweep(input string tag, input int n);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (flush_busy !== 1'b1 || req_rdy !== 1'b0) bad = 1'b1;
    end
    chk1({tag, ":held_busy"}, bad, 1'b0);
    tick();
    chk1({tag, ":rdy_after"}, req_rdy, 1'b1);
    chk1({tag, ":busy_after"}, flush_busy, 1'b0);
  endtask

  // inv_step: 1 = inv during RD, 2 = during CMP, 3 = coincident with mem_ack
  task automatic access(input string tag, input logic [4:0] ch, input logic [31:0] adr,
                        input bit exp_hit, input logic [127:0] dat, input int delay,
                        input int inv_step, input bit flush_mid);
    logic [31:0] la;
    bit          bad;
    la = adr & 32'hFFFF_FFF0;
    chk1({tag, ":rdy"}, req_rdy, 1'b1);
    req = 1'b1; req_ch = ch; req_adr = adr;
    inv_ch = ch; inv_adr = adr;
    tick();
    req = 1'b0; inv = (inv_step == 1);
    tick();
    inv = (inv_step == 2);
    tick();
    inv = 1'b0;
    if (exp_hit) begin
      chk1({tag, ":rsp_vld"}, rsp_vld, 1'b1);
      chk1({tag, ":rsp_hit"}, rsp_hit, 1'b1);
      chk({tag, ":rsp_dat"}, rsp_dat, dat);
      chk1({tag, ":no_mem_req"}, mem_req, 1'b0);
    end else begin
      chk1({tag, ":mem_req"}, mem_req, 1'b1);
      chk({tag, ":mem_adr"}, 128'(mem_adr), 128'(la));
      chk1({tag, ":no_early_rsp"}, rsp_vld, 1'b0);
      bad = 1'b0;
      for (int i = 0; i < delay; i++) begin
        flush = flush_mid && (i == 0);
        tick();
        if (mem_req !== 1'b1 || mem_adr !== la || rsp_vld !== 1'b0) bad = 1'b1;
      end
      flush = 1'b0;
      chk1({tag, ":mem_stable"}, bad, 1'b0);
      mem_ack = 1'b1; mem_dat = dat; inv = (inv_step == 3);
      tick();
      mem_ack = 1'b0; mem_dat = '0; inv = 1'b0;
      chk1({tag, ":rsp_vld"}, rsp_vld, 1'b1);
      chk1({tag, ":rsp_hit"}, rsp_hit, 1'b0);
      chk({tag, ":rsp_dat"}, rsp_dat, dat);
      chk1({tag, ":mem_req_drop"}, mem_req, 1'b0);
      chk1({tag, ":rdy_back"}, req_rdy, 1'b1);
    end
    tick();
    chk1({tag, ":rsp_pulse"}, rsp_vld, 1'b0);
    chk({tag, ":rsp_held"}, rsp_dat, dat);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk1("rst:flush_busy", flush_busy, 1'b1);
    chk1("rst:req_rdy", req_rdy, 1'b0);
    chk1("rst:rsp_vld", rsp_vld, 1'b0);
    chk1("rst:rsp_hit", rsp_hit, 1'b0);
    chk1("rst:mem_req", mem_req, 1'b0);
    chk("rst:mem_adr", 128'(mem_adr), 128'd0);
    chk("rst:rsp_dat", rsp_dat, 128'd0);
    chk("rst:hit_cnt", 128'(hit_cnt), 128'd0);
    chk("rst:miss_cnt", 128'(miss_cnt), 128'd0);
    rst = 1'b0;
    wait_sweep("init_sweep", 511);
    chk("init:hit_cnt", 128'(hit_cnt), 128'd0);
    chk("init:miss_cnt", 128'(miss_cnt), 128'd0);

    // Cold miss with zero-wait ack, then hit
    access("cold_miss", 5'd3, 32'h0000_1230, 1'b0, {16{8'hA5}}, 0, 0, 1'b0);
    access("rehit", 5'd3, 32'h0000_1230, 1'b1, {16{8'hA5}}, 0, 0, 1'b0);
    chk("cnt1:hit", 128'(hit_cnt), 128'd1);
    chk("cnt1:miss", 128'(miss_cnt), 128'd1);

    // Aliasing tag and channel isolation
    access("alias", 5'd3, 32'h0001_1230, 1'b0, {16{8'hB6}}, 3, 0, 1'b0);
    access("ch4_miss", 5'd4, 32'h0001_1230, 1'b0, {16{8'hC7}}, 1, 0, 1'b0);
    access("ch3_hit", 5'd3, 32'h0001_1230, 1'b1, {16{8'hB6}}, 0, 0, 1'b0);
    access("ch4_hit", 5'd4, 32'h0001_1230, 1'b1, {16{8'hC7}}, 0, 0, 1'b0);

    // Invalidate during CMP and during RD forces a miss
    access("inv_cmp", 5'd3, 32'h0001_1230, 1'b0, {16{8'hD8}}, 1, 2, 1'b0);
    access("inv_cmp_refill", 5'd3, 32'h0001_1230, 1'b1, {16{8'hD8}}, 0, 0, 1'b0);
    access("inv_rd", 5'd4, 32'h0001_1230, 1'b0, {16{8'hE9}}, 0, 1, 1'b0);

    // Invalidate coincident with fill: data returned, line stays invalid
    access("inv_fill", 5'd3, 32'h0000_1230, 1'b0, {16{8'hF0}}, 2, 3, 1'b0);
    access("after_inv_fill", 5'd3, 32'h0000_1230, 1'b0, {16{8'h11}}, 0, 0, 1'b0);
    chk("cnt2:hit", 128'(hit_cnt), 128'd4);
    chk("cnt2:miss", 128'(miss_cnt), 128'd7);

    // Flush during MWAIT is latched and swept after the response
    access("flush_mwait", 5'd5, 32'h0000_2000, 1'b0, {16{8'h22}}, 2, 0, 1'b1);
    chk1("pend:busy", flush_busy, 1'b1);
    wait_sweep("pend_sweep", 511);
    access("post_flush_a", 5'd3, 32'h0000_1230, 1'b0, {16{8'h33}}, 0, 0, 1'b0);
    access("post_flush_b", 5'd5, 32'h0000_2000, 1'b0, {16{8'h44}}, 1, 0, 1'b0);

    // Simultaneous flush and req: flush wins, req held until after sweep
    flush = 1'b1; req = 1'b1; req_ch = 5'd4; req_adr = 32'h0001_1230;
    tick();
    flush = 1'b0;
    chk1("simul:busy", flush_busy, 1'b1);
    chk1("simul:not_rdy", req_rdy, 1'b0);
    wait_sweep("simul_sweep", 511);
    access("slow_ack", 5'd4, 32'h0001_1230, 1'b0, {16{8'h55}}, 50, 0, 1'b0);
    chk("cnt3:hit", 128'(hit_cnt), 128'd4);
    chk("cnt3:miss", 128'(miss_cnt), 128'd11);

    // Reset mid-miss drops mem_req without waiting for a clock
    req = 1'b1; req_ch = 5'd6; req_adr = 32'h0000_3000;
    tick();
    req = 1'b0;
    tick(); tick();
    chk1("midmiss:mem_req", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("async_rst:mem_req", mem_req, 1'b0);
    chk("async_rst:miss_cnt", 128'(miss_cnt), 128'd0);
    chk1("async_rst:busy", flush_busy, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
